// File: rtl/roll_controller_if.sv
// Die-select input and display/status outputs of the roll controller.
// The controller uses the master side; the encoder and display use the slave side.
interface roll_controller_if;
  logic [3:0] die_select;
  logic [4:0] roll_value;
  logic [4:0] die_sides;
  logic       rolling;
  logic       result_valid;
  logic       done_pulse;
  logic       test_active;

  modport master (
    input  die_select,
    output roll_value, die_sides, rolling, result_valid, done_pulse, test_active
  );

  modport slave (
    output die_select,
    input  roll_value, die_sides, rolling, result_valid, done_pulse, test_active
  );
endinterface

// File: rtl/roll_controller.sv
// Dice-roll sequencer: synchronises and debounces the die-select code, spins a face
// counter while the button is held and latches the final face on a debounced release.
module roll_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_ROLL_CYCLES = 64,
  parameter int unsigned ANIM_DIV        = 4
) (
  input logic               clk,
  input logic               reset,
  roll_controller_if.master rollBus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RW = $clog2(MIN_ROLL_CYCLES) + 1;
  localparam int unsigned AW = $clog2(ANIM_DIV) + 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] ROLL_MIN  = RW'(MIN_ROLL_CYCLES - 1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

  localparam logic [3:0] NONE_CODE = 4'b1111;
  localparam logic [3:0] TEST_CODE = 4'b0111;
  localparam logic [4:0] TEST_LAST_FACE = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ROLL,
    TEST
  } stateE;

  stateE state, stateNxt;

  logic [3:0]    sync1, sSel;
  logic [3:0]    cand, candNxt;
  logic [DW-1:0] dcnt, dcntNxt;
  logic [DW-1:0] rcnt, rcntNxt;
  logic [RW-1:0] rollCnt, rollCntNxt;
  logic [AW-1:0] animCnt, animCntNxt;
  logic [4:0]    face, faceNxt;
  logic [4:0]    rollValue, rollValueNxt;
  logic [4:0]    dieSides, dieSidesNxt;
  logic          rolling, rollingNxt;
  logic          resultValid, resultValidNxt;
  logic          donePulse, donePulseNxt;
  logic          testActive, testActiveNxt;

  logic          releaseDone;
  logic          animTick;
  logic [4:0]    candSides;
  logic [4:0]    faceShown;

  function automatic logic [4:0] sideMap(input logic [3:0] code);
    case (code)
      4'b0000: sideMap = 5'd4;
      4'b0001: sideMap = 5'd6;
      4'b0010: sideMap = 5'd8;
      4'b0011: sideMap = 5'd10;
      4'b0100: sideMap = 5'd12;
      4'b0101: sideMap = 5'd20;
      default: sideMap = '0;
    endcase
  endfunction

  assign candSides   = sideMap(cand);
  assign releaseDone = (sSel != cand) && (rcnt == DEB_LAST);
  assign animTick    = (animCnt == ANIM_LAST);
  assign faceShown   = 5'(face + 5'd1);

  // State and datapath registers; the synchroniser resets to the "no button" code.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '1;
      sSel        <= '1;
      state       <= IDLE;
      cand        <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      rollCnt     <= '0;
      animCnt     <= '0;
      face        <= '0;
      rollValue   <= '0;
      dieSides    <= '0;
      rolling     <= 1'b0;
      resultValid <= 1'b0;
      donePulse   <= 1'b0;
      testActive  <= 1'b0;
    end else begin
      sync1       <= rollBus.die_select;
      sSel        <= sync1;
      state       <= stateNxt;
      cand        <= candNxt;
      dcnt        <= dcntNxt;
      rcnt        <= rcntNxt;
      rollCnt     <= rollCntNxt;
      animCnt     <= animCntNxt;
      face        <= faceNxt;
      rollValue   <= rollValueNxt;
      dieSides    <= dieSidesNxt;
      rolling     <= rollingNxt;
      resultValid <= resultValidNxt;
      donePulse   <= donePulseNxt;
      testActive  <= testActiveNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (sSel != NONE_CODE) stateNxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (sSel != cand) begin
          stateNxt = IDLE;
        end else if (dcnt == DEB_LAST) begin
          if (candSides != '0)         stateNxt = ROLL;
          else if (cand == TEST_CODE)  stateNxt = TEST;
          else                         stateNxt = IDLE;
        end
      end
      ROLL: begin
        if (releaseDone && (rollCnt >= ROLL_MIN)) stateNxt = IDLE;
      end
      TEST: begin
        if (releaseDone) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    candNxt        = cand;
    dcntNxt        = dcnt;
    rcntNxt        = rcnt;
    rollCntNxt     = rollCnt;
    animCntNxt     = animCnt;
    faceNxt        = face;
    rollValueNxt   = rollValue;
    dieSidesNxt    = dieSides;
    rollingNxt     = rolling;
    resultValidNxt = resultValid;
    donePulseNxt   = 1'b0;
    testActiveNxt  = testActive;

    case (state)
      IDLE: begin
        if (sSel != NONE_CODE) begin
          candNxt = sSel;
          dcntNxt = '0;
        end
      end

      DEBOUNCE: begin
        if (sSel == cand) begin
          if (dcnt != DEB_LAST) dcntNxt = DW'(dcnt + 1'b1);
          if (dcnt == DEB_LAST) begin
            if (candSides != '0) begin
              dieSidesNxt    = candSides;
              faceNxt        = '0;
              rollCntNxt     = '0;
              rcntNxt        = '0;
              animCntNxt     = '0;
              rollingNxt     = 1'b1;
              resultValidNxt = 1'b0;
            end else if (cand == TEST_CODE) begin
              testActiveNxt  = 1'b1;
              resultValidNxt = 1'b0;
              faceNxt        = '0;
              animCntNxt     = '0;
              rcntNxt        = '0;
            end
          end
        end
      end

      ROLL: begin
        faceNxt    = (face == 5'(dieSides - 5'd1)) ? '0 : faceShown;
        if (rollCnt != '1) rollCntNxt = RW'(rollCnt + 1'b1);
        animCntNxt = animTick ? '0 : AW'(animCnt + 1'b1);
        if (animTick) rollValueNxt = faceShown;
        if (sSel == cand)          rcntNxt = '0;
        else if (rcnt != DEB_LAST) rcntNxt = DW'(rcnt + 1'b1);
        // The final latch uses the pre-update face and wins over the animation update.
        if (releaseDone && (rollCnt >= ROLL_MIN)) begin
          rollValueNxt   = faceShown;
          rollingNxt     = 1'b0;
          resultValidNxt = 1'b1;
          donePulseNxt   = 1'b1;
        end
      end

      TEST: begin
        // The sweep advances one face per display update so the display steps 1,2,3...
        animCntNxt = animTick ? '0 : AW'(animCnt + 1'b1);
        if (animTick) begin
          rollValueNxt = faceShown;
          faceNxt      = (face == TEST_LAST_FACE) ? '0 : faceShown;
        end
        if (sSel == cand)          rcntNxt = '0;
        else if (rcnt != DEB_LAST) rcntNxt = DW'(rcnt + 1'b1);
        if (releaseDone) begin
          rollValueNxt  = '0;
          dieSidesNxt   = '0;
          testActiveNxt = 1'b0;
        end
      end

      default: ;
    endcase
  end

  assign rollBus.roll_value   = rollValue;
  assign rollBus.die_sides    = dieSides;
  assign rollBus.rolling      = rolling;
  assign rollBus.result_valid = resultValid;
  assign rollBus.done_pulse   = donePulse;
  assign rollBus.test_active  = testActive;

endmodule

// File: tb/tb_roll_controller.sv
// Directed bench for roll_controller with DEBOUNCE_CYCLES=4, MIN_ROLL_CYCLES=64, ANIM_DIV=4.
module tb_roll_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  roll_controller_if rif ();

  roll_controller #(
    .DEBOUNCE_CYCLES(4),
    .MIN_ROLL_CYCLES(64),
    .ANIM_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rollBus(rif)
  );

  always #5 clk = ~clk;

  // {roll_value, die_sides, rolling, result_valid, done_pulse, test_active}
  logic [14:0] obs;
  assign obs = {rif.roll_value, rif.die_sides, rif.rolling, rif.result_valid,
                rif.done_pulse, rif.test_active};

  function automatic logic [14:0] pack(input int rv, input int ds, input bit r,
                                       input bit v, input bit d, input bit t);
    return {5'(rv), 5'(ds), r, v, d, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    reset = 1'b1;
    rif.die_select = 4'b0101;
    repeat (3) tick();
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 15'd0);
    end
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (rif.rolling !== 1'b0) begin
      errors++;
      $display("FAIL press_latency_early: rolling=%b expected 0 after edge 6", rif.rolling);
    end
    tick();
    exp = pack(0, 20, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL press_latency_edge7: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_d6_stop();
    logic [14:0] exp;
    reset = 1'b1;
    rif.die_select = 4'b1111;
    repeat (2) tick();
    reset = 1'b0;
    rif.die_select = 4'b0001;
    repeat (7) tick();
    checks++;
    if ({rif.rolling, rif.die_sides} !== {1'b1, 5'd6}) begin
      errors++;
      $display("FAIL d6_start: rolling=%b die_sides=%0d expected 1/6", rif.rolling, rif.die_sides);
    end
    repeat (94) tick();
    rif.die_select = 4'b1111;
    repeat (5) tick();
    checks++;
    if ({rif.rolling, rif.done_pulse} !== 2'b10) begin
      errors++;
      $display("FAIL d6_before_stop: rolling=%b done=%b expected 1/0", rif.rolling, rif.done_pulse);
    end
    tick();
    exp = pack(4, 6, 0, 1, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL d6_stop_edge: got %h expected %h", obs, exp);
    end
    tick();
    exp = pack(4, 6, 0, 1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL d6_after_stop: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_min_roll();
    logic [14:0] exp;
    bit          early;
    rif.die_select = 4'b0000;
    repeat (7) tick();
    exp = pack(4, 4, 1, 0, 0, 0);
    checks++;
    if ({rif.die_sides, rif.rolling, rif.result_valid} !== {5'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL d4_restart: got %h expected %h", obs, exp);
    end
    repeat (10) tick();
    rif.die_select = 4'b1111;
    early = 1'b0;
    for (int k = 11; k <= 63; k++) begin
      tick();
      if (rif.rolling !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL min_roll_hold: stopped early=%b expected 0", early);
    end
    tick();
    checks++;
    if (obs !== exp) begin
      if (obs !== pack(4, 4, 0, 1, 1, 0)) begin
        errors++;
        $display("FAIL min_roll_stop: got %h expected %h", obs, pack(4, 4, 0, 1, 1, 0));
      end
    end else begin
      errors++;
      $display("FAIL min_roll_stop: got %h expected %h", obs, pack(4, 4, 0, 1, 1, 0));
    end
  endtask

  task automatic test_glitch();
    logic [14:0] exp;
    exp = pack(4, 4, 0, 1, 0, 0);
    rif.die_select = 4'b0010;
    repeat (2) tick();
    rif.die_select = 4'b1111;
    repeat (10) tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL short_glitch: got %h expected %h", obs, exp);
    end
    rif.die_select = 4'b0110;
    repeat (10) tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL invalid_code_held: got %h expected %h", obs, exp);
    end
    rif.die_select = 4'b1111;
    repeat (6) tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL invalid_code_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_test_mode();
    logic [14:0] exp;
    rif.die_select = 4'b0111;
    repeat (7) tick();
    exp = pack(4, 4, 0, 0, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL test_entry: got %h expected %h", obs, exp);
    end
    for (int j = 1; j <= 33; j++) begin
      tick();
      if ((j % 4) == 0 && j <= 12) begin
        checks++;
        if (rif.roll_value !== 5'(j / 4)) begin
          errors++;
          $display("FAIL test_sweep_j%0d: roll_value=%0d expected %0d", j, rif.roll_value, j / 4);
        end
      end
    end
    checks++;
    if (rif.roll_value !== 5'd8) begin
      errors++;
      $display("FAIL test_sweep_held: roll_value=%0d expected 8", rif.roll_value);
    end
    rif.die_select = 4'b1111;
    repeat (5) tick();
    exp = pack(9, 4, 0, 0, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL test_before_exit: got %h expected %h", obs, exp);
    end
    tick();
    exp = pack(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL test_exit: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_roll();
    logic [14:0] exp;
    rif.die_select = 4'b0101;
    repeat (7) tick();
    checks++;
    if (rif.rolling !== 1'b1) begin
      errors++;
      $display("FAIL d20_start: rolling=%b expected 1", rif.rolling);
    end
    repeat (20) tick();
    reset = 1'b1;
    rif.die_select = 4'b0100;
    tick();
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_roll: got %h expected %h", obs, 15'd0);
    end
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (rif.rolling !== 1'b0) begin
      errors++;
      $display("FAIL d12_early: rolling=%b expected 0", rif.rolling);
    end
    tick();
    exp = pack(0, 12, 1, 0, 0, 0);
    checks++;
    if ({rif.die_sides, rif.rolling, rif.result_valid, rif.done_pulse} !== {5'd12, 3'b100}) begin
      errors++;
      $display("FAIL d12_start: got %h expected sides/flags of %h", obs, exp);
    end
    rif.die_select = 4'b1111;
    repeat (63) tick();
    checks++;
    if (rif.rolling !== 1'b1) begin
      errors++;
      $display("FAIL d12_hold: rolling=%b expected 1", rif.rolling);
    end
    tick();
    exp = pack(4, 12, 0, 1, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL d12_stop: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    rif.die_select = 4'b1111;
    test_reset();
    test_d6_stop();
    test_min_roll();
    test_glitch();
    test_test_mode();
    test_reset_mid_roll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
